// File: rtl/fetch_entry_queue.sv
// Fetch-entry FIFO between frontend and ID stage: decouples decode backpressure,
// drops everything on flush and stops accepting after a faulting fetch.
package ariane_pkg;
  typedef struct packed {
    logic [31:0] cause;
    logic [31:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [1:0]  cf_type;
    logic [31:0] predict_address;
  } branchpredict_sbe_t;

  typedef struct packed {
    logic [31:0]        address;
    logic [31:0]        instruction;
    branchpredict_sbe_t branch_predict;
    exception_t         ex;
  } fetch_entry_t;
endpackage

module fetch_entry_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  ariane_pkg::fetch_entry_t   fetch_entry_i,
  input  logic                       fetch_entry_valid_i,
  output logic                       fetch_entry_ready_o,
  output ariane_pkg::fetch_entry_t   fetch_entry_o,
  output logic                       fetch_entry_valid_o,
  input  logic                       fetch_entry_ready_i,
  output logic [$clog2(DEPTH):0]     usage_o,
  output logic                       ex_blocked_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  ariane_pkg::fetch_entry_t mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          ex_blocked_q;
  logic          push, pop;

  // Ready depends only on registered state, so a pop never frees a slot
  // for a push in the same cycle.
  assign fetch_entry_ready_o = !rst_i && !flush_i && !ex_blocked_q && (cnt_q < CW'(DEPTH));
  assign fetch_entry_valid_o = (cnt_q != '0) && !rst_i;
  assign fetch_entry_o       = mem_q[rd_ptr_q];
  assign usage_o             = cnt_q;
  assign ex_blocked_o        = ex_blocked_q;

  assign push = fetch_entry_valid_i && fetch_entry_ready_o;
  assign pop  = fetch_entry_valid_o && fetch_entry_ready_i && !flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      ex_blocked_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      // Everything behind a faulting fetch is wrong-path; hold input until flush.
      if (push && fetch_entry_i.ex.valid) ex_blocked_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= fetch_entry_i;
  end

`ifndef SYNTHESIS
  a_cnt_range: assert property (@(posedge clk_i) disable iff (rst_i) cnt_q <= CW'(DEPTH));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) push |-> (cnt_q != CW'(DEPTH)));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) pop |-> (cnt_q != '0));
`endif
endmodule

// File: tb/tb_fetch_entry_queue.sv
// Randomized + directed bench for fetch_entry_queue against a queue-based reference model.
module tb_fetch_entry_queue;
  import ariane_pkg::*;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst, flush, vld_i, rdy_i;
  fetch_entry_t fe_i, fe_o;
  logic         rdy_o, vld_o, blk_o;
  logic [2:0]   usage;

  int total = 0;
  int bad   = 0;

  fetch_entry_t mq[$];
  bit           m_blk;

  always #5 clk = ~clk;

  fetch_entry_queue #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .fetch_entry_i(fe_i), .fetch_entry_valid_i(vld_i), .fetch_entry_ready_o(rdy_o),
    .fetch_entry_o(fe_o), .fetch_entry_valid_o(vld_o), .fetch_entry_ready_i(rdy_i),
    .usage_o(usage), .ex_blocked_o(blk_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic fetch_entry_t mk(input logic [31:0] addr, input logic ex);
    fetch_entry_t e;
    e = '0;
    e.address     = addr;
    e.instruction = $urandom;
    e.branch_predict.predict_address = $urandom;
    e.ex.cause    = $urandom;
    e.ex.valid    = ex;
    return e;
  endfunction

  // Inputs are already applied; check outputs against the model, then advance one edge.
  task automatic cycle();
    bit exp_rdy, exp_vld;
    #1;
    exp_rdy = !rst && !flush && !m_blk && (mq.size() < DEPTH);
    exp_vld = (mq.size() != 0) && !rst;
    chk("ready_o", 64'(rdy_o), 64'(exp_rdy));
    chk("valid_o", 64'(vld_o), 64'(exp_vld));
    chk("usage_o", 64'(usage), 64'(mq.size()));
    chk("ex_blocked_o", 64'(blk_o), 64'(m_blk));
    if (exp_vld) begin
      chk("head_addr", 64'(fe_o.address), 64'(mq[0].address));
      chk("head_insn", 64'(fe_o.instruction), 64'(mq[0].instruction));
      chk("head_ex", 64'(fe_o.ex.valid), 64'(mq[0].ex.valid));
    end
    @(posedge clk);
    if (rst || flush) begin
      mq.delete();
      m_blk = 1'b0;
    end else begin
      if (exp_vld && rdy_i) void'(mq.pop_front());
      if (vld_i && exp_rdy) begin
        mq.push_back(fe_i);
        if (fe_i.ex.valid) m_blk = 1'b1;
      end
    end
    #1;
  endtask

  task automatic drive(input bit r, input bit f, input bit v, input bit rd, input fetch_entry_t e);
    rst = r; flush = f; vld_i = v; rdy_i = rd; fe_i = e;
  endtask

  initial begin
    drive(1, 0, 0, 0, '0);
    m_blk = 0;
    @(posedge clk); #1;
    cycle();                                  // reset state observed with rst high

    // Fill A0..A3 with ID stalled
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, mk(32'h8000_0000 + 32'(4*i), 0));
      cycle();
    end
    chk("full_usage", 64'(usage), 64'd4);
    chk("full_head", 64'(fe_o.address), 64'h8000_0000);

    // Full + pop same cycle: push refused
    drive(0, 0, 1, 1, mk(32'h8000_0010, 0));
    cycle();
    chk("after_full_pop_usage", 64'(usage), 64'd3);
    drive(0, 0, 0, 0, '0);
    cycle();
    drive(0, 1, 0, 0, '0);
    cycle();

    // Streaming across several pointer wraps
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, 1, mk(32'h9000_0000 + 32'(4*i), 0));
      cycle();
    end
    drive(0, 0, 0, 1, '0);
    cycle();

    // Exception block
    drive(0, 0, 1, 0, mk(32'hB000_0000, 0)); cycle();
    drive(0, 0, 1, 0, mk(32'hB000_0004, 1)); cycle();
    drive(0, 0, 1, 0, mk(32'hB000_0008, 0)); cycle();
    chk("ex_block_set", 64'(blk_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, mk(32'hB000_0008, 0)); cycle();
    end
    chk("ex_drained_usage", 64'(usage), 64'd0);
    drive(0, 1, 0, 0, '0); cycle();
    drive(0, 0, 0, 0, '0); cycle();
    chk("ex_cleared_ready", 64'(rdy_o), 64'd1);

    // Flush with 3 entries while offering/popping
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, mk(32'hC000_0000 + 32'(4*i), 0)); cycle();
    end
    drive(0, 1, 1, 1, mk(32'hC000_0100, 0)); cycle();
    drive(0, 0, 0, 0, '0); cycle();

    // Reset concurrent with flush while holding 2 entries
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 0, mk(32'hD000_0000 + 32'(4*i), 0)); cycle();
    end
    drive(1, 1, 1, 1, mk(32'hD000_0100, 0)); cycle();
    drive(0, 0, 0, 0, '0); cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) < 1), ($urandom_range(0, 99) < 4),
            ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 55),
            mk($urandom, ($urandom_range(0, 99) < 5)));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_entry_queue.md
Name: fetch_entry_queue

Overview:
- Small circular FIFO between the frontend fetch output and the ID stage's fetch-entry handshake.
- Decouples frontend from decode backpressure and drops all instructions on a pipeline flush.
- Stops accepting new entries after an entry carrying a fetch exception, until the next flush. Everything after a faulting fetch is wrong-path.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- flush_i  input  1  discard all stored entries and clear exception block
- fetch_entry_i  input  ariane_pkg::fetch_entry_t  entry from frontend (address, instruction, branch_predict, ex)
- fetch_entry_valid_i  input  1  frontend entry valid
- fetch_entry_ready_o  output  1  queue accepts entry this cycle
- fetch_entry_o  output  ariane_pkg::fetch_entry_t  head entry to ID stage
- fetch_entry_valid_o  output  1  head entry valid
- fetch_entry_ready_i  input  1  ID stage acknowledges head entry
- usage_o  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH
- ex_blocked_o  output  1  an exception entry was accepted; input is stalled

Behaviour:
- State:
  - storage mem[DEPTH], not reset
  - rd_ptr, wr_ptr, each $clog2(DEPTH) bits, wrap naturally modulo DEPTH
  - cnt, $clog2(DEPTH)+1 bits
  - ex_blocked_q
- Reset (rst_i=1 at posedge): rd_ptr=wr_ptr=0, cnt=0, ex_blocked_q=0.
  - While rst_i is high, fetch_entry_ready_o=0 and fetch_entry_valid_o=0.
  - Reset mid-operation drops all entries, same as a flush.
- fetch_entry_ready_o = !rst_i && !flush_i && !ex_blocked_q && (cnt < DEPTH).
  - Purely registered-state based.
  - No full-queue bypass: at cnt==DEPTH, ready_o=0 even if a pop occurs in the same cycle.
- push = fetch_entry_valid_i && fetch_entry_ready_o. On push: mem[wr_ptr] <= fetch_entry_i, wr_ptr++.
- fetch_entry_valid_o = (cnt != 0) && !rst_i. fetch_entry_o = mem[rd_ptr], combinational read.
  - Content is don't-care when valid_o=0.
- pop = fetch_entry_valid_o && fetch_entry_ready_i && !flush_i. On pop: rd_ptr++.
- Count update:
  - cnt_next = cnt + push - pop.
  - Simultaneous push and pop leaves cnt unchanged and moves both pointers.
- Latency: an entry pushed at edge N is visible on fetch_entry_o with valid_o=1 in the cycle after edge N. There is no same-cycle fall-through.
- Exception block:
  - On a push with fetch_entry_i.ex.valid=1, ex_blocked_q <= 1.
  - Entries already stored, including the faulting one, still drain normally.
  - ready_o stays 0 until a flush.
- Flush (flush_i=1 at posedge): rd_ptr=wr_ptr=0, cnt=0, ex_blocked_q=0.
  - Any push or pop in that cycle is ignored; ready_o is already 0 during flush.
  - valid_o may still be 1 during the flush cycle; the consumer discards it.
- rst_i takes priority over flush_i. flush_i takes priority over push and pop.
- usage_o = cnt. ex_blocked_o = ex_blocked_q.
- Ordering: strict FIFO. Entries are never reordered or duplicated.
- Assertions (simulation only):
  - cnt <= DEPTH.
  - No push when cnt==DEPTH.
  - No pop when cnt==0.

Test Plan:
- Reset then push A0..A3 (addresses 0x80000000, +4, +8, +C) with ready_i=0 → usage_o steps 1,2,3,4; ready_o=0 after the 4th push; head=0x80000000.
- Full queue (DEPTH=4), valid_i=1 and ready_i=1 together → pop occurs, push is refused that cycle (ready_o=0); next cycle usage_o=3 and ready_o=1.
- Steady streaming with valid_i=ready_i=1 for 20 cycles → 1-cycle latency; output addresses match input order across more than 4 pointer wraps; usage_o stays at 1.
- Push B0, B1 (ex.valid=1), B2 → B2 refused; ex_blocked_o=1; B0 then B1 pop in order; ready_o stays 0 with queue empty; flush_i pulse → ex_blocked_o=0, ready_o=1.
- Queue holding 3 entries, flush_i=1 while valid_i=1 and ready_i=1 → next cycle usage_o=0, valid_o=0; the entry offered during the flush is not stored.
- Queue holding 2 entries, rst_i asserted 1 cycle concurrently with flush_i → all state zero, valid_o=0 and ready_o=0 while rst_i is high, ready_o=1 the cycle after.
